dct88_mac_engine: RTL

Parametrised 8x8 2D forward DCT engine for the JPEG encode path. It is the multi-channel, width-configurable successor to the fixed 8-bit single-block DCT. It fetches one 8x8 block of signed samples from a synchronous-read EBR, runs a row pass and then a column pass through a single multiply-accumulator and an internal transpose scratchpad, and writes 64 coefficients to an output EBR in either natural or zig-zag order. Each block is addressed by a channel index, so one engine serves Y/Cb/Cr.

---
 rtl/dct88_pkg.sv | 49 ++++
 rtl/dct88_mac.sv | 36 +++
 rtl/ice40_ebr.sv | 19 +
 rtl/dct88_mac_engine.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dct88_pkg.sv
// Shared constants for the 8x8 forward DCT engine: cosine table (11 fractional bits),
// JPEG zig-zag map, FSM state encodings and the saturation helper.
package dct88_pkg;

    localparam int COEF_W = 12;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ROW  = 2'd1;
    localparam state_t ST_COL  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef logic signed [COEF_W-1:0] coef_t;

    // COS_LUT[u][x] = round(2048 * 0.5 * C(u) * cos((2x+1)u*pi/16))
    localparam coef_t COS_LUT [8][8] = '{
        '{ 12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724 },
        '{ 12'sd1004,  12'sd851,   12'sd569,   12'sd200,  -12'sd200,  -12'sd569,  -12'sd851,  -12'sd1004 },
        '{ 12'sd946,   12'sd392,  -12'sd392,  -12'sd946,  -12'sd946,  -12'sd392,   12'sd392,   12'sd946 },
        '{ 12'sd851,  -12'sd200,  -12'sd1004, -12'sd569,   12'sd569,   12'sd1004,  12'sd200,  -12'sd851 },
        '{ 12'sd724,  -12'sd724,  -12'sd724,   12'sd724,   12'sd724,  -12'sd724,  -12'sd724,   12'sd724 },
        '{ 12'sd569,  -12'sd1004,  12'sd200,   12'sd851,  -12'sd851,  -12'sd200,   12'sd1004, -12'sd569 },
        '{ 12'sd392,  -12'sd946,   12'sd946,  -12'sd392,  -12'sd392,   12'sd946,  -12'sd946,   12'sd392 },
        '{ 12'sd200,  -12'sd569,   12'sd851,  -12'sd1004,  12'sd1004, -12'sd851,   12'sd569,  -12'sd200 }
    };

    // Natural index (8v+u) -> position in the JPEG zig-zag scan.
    localparam logic [5:0] ZIGZAG_LUT [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)      return hi;
        else if (value < lo) return lo;
        else                 return value;
    endfunction

endpackage

// File: rtl/dct88_mac.sv
// 8-tap multiply-accumulate with round-half-up and dual saturation widths,
// shared by the row pass (16-bit result) and the column pass (OUT_WIDTH result).
module dct88_mac
    import dct88_pkg::*;
#(
    parameter int OUT_WIDTH = 16,
    parameter int ACC_W     = 31,
    parameter int COEF_FRAC = 11
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        acc_en,
    input  logic signed [COEF_W-1:0]    coef,
    input  logic signed [15:0]          sample,
    output logic signed [15:0]          row_result,
    output logic signed [OUT_WIDTH-1:0] col_result
);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (COEF_FRAC - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] product;
    logic signed [ACC_W-1:0] rounded;
    logic signed [63:0]      rounded_ext;

    assign product     = ACC_W'(coef) * ACC_W'(sample);
    assign rounded     = (acc + HALF) >>> COEF_FRAC;
    assign rounded_ext = 64'(rounded);
    assign row_result  = 16'(saturate(rounded_ext, 16));
    assign col_result  = OUT_WIDTH'(saturate(rounded_ext, OUT_WIDTH));

    always_ff @(posedge clock) begin
        if (reset || clear) acc <= '0;
        else if (acc_en)    acc <= acc + product;
    end
endmodule

// File: rtl/ice40_ebr.sv
// Simple dual-port embedded block RAM with registered (one-cycle) read.
module ice40_ebr #(
    parameter int addr_width = 8,
    parameter int data_width = 16
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);
    logic [data_width-1:0] mem [1 << addr_width];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/dct88_mac_engine.sv
// 8x8 forward DCT: row pass into a transposed scratchpad, column pass to the result EBR.
//   state   | meaning
//   IDLE    | waiting for an accepted start
//   ROW     | 64 row outputs, source -> scratch at 8u+r
//   COL     | 64 column outputs, scratch -> result EBR
//   DONE    | single cycle, raises finished
module dct88_mac_engine
    import dct88_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int COEF_FRAC = 11,
    parameter int CHANNELS  = 3,
    localparam int CH_W     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CH_W-1:0]      channel,
    input  logic                 zigzag,
    output logic                 busy,
    output logic                 finished,
    output logic [CH_W+5:0]      fetch_addr,
    input  logic [IN_WIDTH-1:0]  src_data_in,
    output logic [CH_W+5:0]      result_write_addr,
    output logic                 result_wren,
    output logic [OUT_WIDTH-1:0] result_out
);
    localparam int ACC_W = ((IN_WIDTH > 16) ? IN_WIDTH : 16) + COEF_W + 3;

    state_t          state;
    logic [3:0]      phase;
    logic [2:0]      freq;
    logic [2:0]      line;
    logic [CH_W-1:0] ch;
    logic            zz;
    logic [CH_W+5:0] fetch_hold;
    logic [CH_W+5:0] fetch_live;
    logic            fetch_live_en;
    logic            in_pass;
    logic            last_phase;
    logic            last_out;
    logic            accept;
    logic [2:0]      tap;
    logic [5:0]      nat_idx;
    logic [15:0]     scratch_rd;
    logic signed [15:0]          sample;
    logic signed [15:0]          row_result;
    logic signed [OUT_WIDTH-1:0] col_result;

    assign in_pass    = (state == ST_ROW) || (state == ST_COL);
    assign last_phase = (phase == 4'd9);
    assign last_out   = last_phase && (freq == 3'd7) && (line == 3'd7);
    assign accept     = start && (state == ST_IDLE) && (32'(channel) < CHANNELS);
    assign tap        = 3'(phase - 4'd1);

    // Live address during the eight read cycles; otherwise the last issued one is held.
    assign fetch_live    = {ch, line, phase[2:0]};
    assign fetch_live_en = (state == ST_ROW) && (phase < 4'd8);
    assign fetch_addr    = fetch_live_en ? fetch_live : fetch_hold;

    assign sample = (state == ST_COL) ? $signed(scratch_rd) : 16'(signed'(src_data_in));

    // In COL, line is the horizontal frequency u and freq is the vertical frequency v.
    assign nat_idx           = {freq, line};
    assign result_write_addr = {ch, zz ? ZIGZAG_LUT[nat_idx] : nat_idx};
    assign result_wren       = (state == ST_COL) && last_phase;
    assign result_out        = col_result;
    assign busy              = (state != ST_IDLE);
    assign finished          = (state == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            phase      <= '0;
            freq       <= '0;
            line       <= '0;
            ch         <= '0;
            zz         <= 1'b0;
            fetch_hold <= '0;
        end else begin
            if (fetch_live_en) fetch_hold <= fetch_live;
            case (state)
                ST_IDLE: if (accept) begin
                    state <= ST_ROW;
                    ch    <= channel;
                    zz    <= zigzag;
                    phase <= '0;
                    freq  <= '0;
                    line  <= '0;
                end
                ST_ROW, ST_COL: begin
                    if (last_phase) begin
                        phase <= '0;
                        freq  <= freq + 3'd1;
                        if (freq == 3'd7) line <= line + 3'd1;
                        if (last_out) state <= (state == ST_ROW) ? ST_COL : ST_DONE;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ice40_ebr #(.addr_width(8), .data_width(16)) u_scratch (
        .clock   (clock),
        .wr_en   ((state == ST_ROW) && last_phase),
        .wr_addr ({freq, line}),
        .wr_data (row_result),
        .rd_addr ({line, phase[2:0]}),
        .rd_data (scratch_rd)
    );

    dct88_mac #(.OUT_WIDTH(OUT_WIDTH), .ACC_W(ACC_W), .COEF_FRAC(COEF_FRAC)) u_mac (
        .clock      (clock),
        .reset      (reset),
        .clear      (phase == 4'd0),
        .acc_en     (in_pass && (phase != 4'd0) && (phase <= 4'd8)),
        .coef       (COS_LUT[freq][tap]),
        .sample     (sample),
        .row_result (row_result),
        .col_result (col_result)
    );
endmodule
